// File: rtl/apple_kb_pkg.sv
// -----------------------------------------------------------------------------
// apple_kb_pkg
// Shared constants and types for the Apple IIe keyboard latch:
//   - HID usage codes recognised by the translator
//   - Apple ASCII codes produced for the non-printing keys
//   - soft-switch base addresses (KBD / KBDSTRB)
//   - HID modifier byte masks (left|right ctrl, left|right shift)
//   - kb_xlat_t translation result {valid, ascii[6:0]}
//   - rpt_state_t states of the typematic repeat controller (KB_REPEAT_EN)
// -----------------------------------------------------------------------------
package apple_kb_pkg;

   // HID usages
   localparam logic [7:0] HID_NONE   = 8'h00;
   localparam logic [7:0] HID_A      = 8'h04;
   localparam logic [7:0] HID_Z      = 8'h1D;
   localparam logic [7:0] HID_1      = 8'h1E;
   localparam logic [7:0] HID_0      = 8'h27;
   localparam logic [7:0] HID_ENTER  = 8'h28;
   localparam logic [7:0] HID_ESC    = 8'h29;
   localparam logic [7:0] HID_BSPACE = 8'h2A;
   localparam logic [7:0] HID_TAB    = 8'h2B;
   localparam logic [7:0] HID_SPACE  = 8'h2C;
   localparam logic [7:0] HID_RIGHT  = 8'h4F;
   localparam logic [7:0] HID_LEFT   = 8'h50;
   localparam logic [7:0] HID_DOWN   = 8'h51;
   localparam logic [7:0] HID_UP     = 8'h52;

   // Apple ASCII
   localparam logic [6:0] ASC_A     = 7'h41;
   localparam logic [6:0] ASC_0     = 7'h30;
   localparam logic [6:0] ASC_1     = 7'h31;
   localparam logic [6:0] ASC_CR    = 7'h0D;
   localparam logic [6:0] ASC_ESC   = 7'h1B;
   localparam logic [6:0] ASC_BS    = 7'h08;
   localparam logic [6:0] ASC_TAB   = 7'h09;
   localparam logic [6:0] ASC_SPACE = 7'h20;
   localparam logic [6:0] ASC_RIGHT = 7'h15;
   localparam logic [6:0] ASC_LEFT  = 7'h08;
   localparam logic [6:0] ASC_DOWN  = 7'h0A;
   localparam logic [6:0] ASC_UP    = 7'h0B;
   localparam logic [6:0] ASC_CTRL_MASK = 7'h1F;

   // Soft switches
   localparam logic [15:0] KBD_ADDR     = 16'hC000;
   localparam logic [15:0] KBDSTRB_ADDR = 16'hC010;

   // HID modifier byte: bit0/bit4 = ctrl, bit1/bit5 = shift
   localparam logic [7:0] MOD_CTRL_MASK  = 8'h11;
   localparam logic [7:0] MOD_SHIFT_MASK = 8'h22;

   typedef struct packed {
      logic       valid;
      logic [6:0] ascii;
   } kb_xlat_t;

   typedef enum logic [1:0] {
      RPT_IDLE,
      RPT_DELAY,
      RPT_RATE
   } rpt_state_t;

   // US-layout shifted digit row, indexed from the '1' key
   function automatic logic [6:0] shifted_digit(input logic [3:0] idx);
      logic [6:0] sym;
      case (idx)
         4'd0:    sym = 7'h21;  // !
         4'd1:    sym = 7'h40;  // @
         4'd2:    sym = 7'h23;  // #
         4'd3:    sym = 7'h24;  // $
         4'd4:    sym = 7'h25;  // %
         4'd5:    sym = 7'h5E;  // ^
         4'd6:    sym = 7'h26;  // &
         4'd7:    sym = 7'h2A;  // *
         4'd8:    sym = 7'h28;  // (
         default: sym = 7'h29;  // )
      endcase
      return sym;
   endfunction

endpackage

// File: rtl/hid_to_ascii.sv
// -----------------------------------------------------------------------------
// hid_to_ascii
// Combinational HID usage -> 7-bit Apple ASCII translator.
// Ports:
//   keycode  in  8  HID usage (0x00 = none)
//   kb_mods  in  8  HID modifier byte
//   valid    out 1  usage is mapped
//   ascii    out 7  translated code (0 when not valid)
// -----------------------------------------------------------------------------
module hid_to_ascii
   import apple_kb_pkg::*;
(
   input  logic [7:0] keycode,
   input  logic [7:0] kb_mods,
   output logic       valid,
   output logic [6:0] ascii
);

   kb_xlat_t   w_res;
   logic       w_ctrl;
   logic       w_shift;
   logic [6:0] w_off;

   always_comb begin
      w_ctrl  = (kb_mods & MOD_CTRL_MASK)  != 8'h00;
      w_shift = (kb_mods & MOD_SHIFT_MASK) != 8'h00;
      w_res   = '0;
      w_off   = '0;
      if (keycode >= HID_A && keycode <= HID_Z) begin
         // letters are always upper case; ctrl folds into the control range
         w_off       = 7'(keycode - HID_A);
         w_res.valid = 1'b1;
         w_res.ascii = ASC_A + w_off;
         if (w_ctrl) begin
            w_res.ascii = w_res.ascii & ASC_CTRL_MASK;
         end
      end else if (keycode >= HID_1 && keycode <= HID_0) begin
         w_off       = 7'(keycode - HID_1);
         w_res.valid = 1'b1;
         if (w_shift) begin
            w_res.ascii = shifted_digit(w_off[3:0]);
         end else if (keycode == HID_0) begin
            w_res.ascii = ASC_0;
         end else begin
            w_res.ascii = ASC_1 + w_off;
         end
      end else begin
         case (keycode)
            HID_ENTER:  w_res = '{valid: 1'b1, ascii: ASC_CR};
            HID_ESC:    w_res = '{valid: 1'b1, ascii: ASC_ESC};
            HID_BSPACE: w_res = '{valid: 1'b1, ascii: ASC_BS};
            HID_TAB:    w_res = '{valid: 1'b1, ascii: ASC_TAB};
            HID_SPACE:  w_res = '{valid: 1'b1, ascii: ASC_SPACE};
            HID_RIGHT:  w_res = '{valid: 1'b1, ascii: ASC_RIGHT};
            HID_LEFT:   w_res = '{valid: 1'b1, ascii: ASC_LEFT};
            HID_DOWN:   w_res = '{valid: 1'b1, ascii: ASC_DOWN};
            HID_UP:     w_res = '{valid: 1'b1, ascii: ASC_UP};
            default:    w_res = '0;
         endcase
      end
   end

   assign valid = w_res.valid;
   assign ascii = w_res.ascii;

endmodule

// File: rtl/apple_kb_latch.sv
// -----------------------------------------------------------------------------
// apple_kb_latch
// Apple IIe keyboard subsystem: HID keycode -> ASCII, keystroke FIFO and the
// KBD ($C000) / KBDSTRB ($C010) soft switches.
// Optional feature macro: KB_REPEAT_EN (typematic auto-repeat of a held key).
// Ports:
//   clk           in   system clock
//   reset_n       in   asynchronous active-low reset
//   keycode       in   HID usage of held key (0x00 = none)
//   kb_mods       in   HID modifier byte
//   addr          in   CPU address bus
//   rw            in   1 = read, 0 = write
//   bus_en        in   valid CPU access strobe
//   data_out      out  soft-switch read data
//   data_sel      out  addr in $C000-$C01F
//   any_key_down  out  registered keycode != 0
//   overflow      out  sticky: a key was dropped on a full FIFO
//   fifo_count    out  FIFO occupancy 0..FIFO_DEPTH
// -----------------------------------------------------------------------------
module apple_kb_latch
   import apple_kb_pkg::*;
#(
   parameter int unsigned FIFO_DEPTH      = 4,
   parameter int unsigned CLK_HZ          = 50000000,
   parameter int unsigned REPEAT_DELAY_MS = 500,
   parameter int unsigned REPEAT_RATE_HZ  = 15
) (
   input  logic                        clk,
   input  logic                        reset_n,
   input  logic [7:0]                  keycode,
   input  logic [7:0]                  kb_mods,
   input  logic [15:0]                 addr,
   input  logic                        rw,
   input  logic                        bus_en,
   output logic [7:0]                  data_out,
   output logic                        data_sel,
   output logic                        any_key_down,
   output logic                        overflow,
   output logic [$clog2(FIFO_DEPTH):0] fifo_count
);

   localparam int unsigned AW = $clog2(FIFO_DEPTH);

   if (FIFO_DEPTH < 2 || FIFO_DEPTH > 16 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_bad_depth
      $error("FIFO_DEPTH must be a power of two in 2..16");
   end
   if (CLK_HZ < 1000 || REPEAT_DELAY_MS == 0 || REPEAT_RATE_HZ == 0 || REPEAT_RATE_HZ > CLK_HZ) begin : g_bad_timing
      $error("repeat timing parameters out of range");
   end

   logic [7:0]    r_keycode;
   logic [7:0]    r_prev;
   logic [7:0]    r_mods;
   logic [6:0]    r_latch;
   logic          r_strobe;
   logic          r_overflow;
   logic [6:0]    r_fifo [FIFO_DEPTH];
   logic [AW-1:0] r_wr_ptr;
   logic [AW-1:0] r_rd_ptr;
   logic [AW:0]   r_count;

   logic          w_valid;
   logic [6:0]    w_ascii;
   logic          w_new_press;
   logic          w_in_kbd;
   logic          w_in_strb;
   logic          w_strb_clr;
   logic          w_pop;
   logic          w_full;
   logic          w_push_req;
   logic          w_push;
   logic          w_drop;
   logic          w_rpt_push;
   logic          w_unused_rw;

   hid_to_ascii u_xlat (
      .keycode (r_keycode),
      .kb_mods (r_mods),
      .valid   (w_valid),
      .ascii   (w_ascii)
   );

   // Reads and writes of KBDSTRB behave identically.
   assign w_unused_rw = rw;

   assign w_new_press = (r_keycode != HID_NONE) && (r_keycode != r_prev);
   assign w_in_kbd    = (addr & 16'hFFF0) == KBD_ADDR;
   assign w_in_strb   = (addr & 16'hFFF0) == KBDSTRB_ADDR;
   assign w_strb_clr  = bus_en && w_in_strb;
   assign w_pop       = !r_strobe && (r_count != '0);
   assign w_full      = r_count == (AW+1)'(FIFO_DEPTH);
   assign w_push_req  = (w_new_press && w_valid) || w_rpt_push;
   // a pop on the same edge frees the slot, so a full FIFO still accepts
   assign w_push      = w_push_req && (!w_full || w_pop);
   assign w_drop      = w_push_req && w_full && !w_pop;

`ifdef KB_REPEAT_EN
   localparam logic [31:0] RPT_DELAY_CYC = 32'((CLK_HZ / 1000) * REPEAT_DELAY_MS);
   localparam logic [31:0] RPT_RATE_CYC  = 32'(CLK_HZ / REPEAT_RATE_HZ);

   rpt_state_t  r_rpt_state;
   rpt_state_t  w_rpt_next;
   logic [31:0] r_rpt_cnt;
   logic [31:0] w_rpt_cnt_next;
   logic        w_held;

   assign w_held = (r_keycode != HID_NONE) && (r_keycode == r_prev) && w_valid;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_rpt_state <= RPT_IDLE;
         r_rpt_cnt   <= '0;
      end else begin
         r_rpt_state <= w_rpt_next;
         r_rpt_cnt   <= w_rpt_cnt_next;
      end
   end

   // The count starts on the edge that pushes the original press; a repeat
   // fires when the key has been held for the full interval since then.
   always_comb begin
      w_rpt_next     = r_rpt_state;
      w_rpt_cnt_next = r_rpt_cnt + 32'd1;
      w_rpt_push     = 1'b0;
      if (w_new_press) begin
         w_rpt_next     = RPT_DELAY;
         w_rpt_cnt_next = '0;
      end else if (!w_held) begin
         w_rpt_next     = RPT_IDLE;
         w_rpt_cnt_next = '0;
      end else begin
         case (r_rpt_state)
            RPT_DELAY: begin
               if (r_rpt_cnt == RPT_DELAY_CYC - 32'd1) begin
                  w_rpt_push     = (r_count == '0);
                  w_rpt_next     = RPT_RATE;
                  w_rpt_cnt_next = '0;
               end
            end
            RPT_RATE: begin
               if (r_rpt_cnt == RPT_RATE_CYC - 32'd1) begin
                  w_rpt_push     = (r_count == '0);
                  w_rpt_cnt_next = '0;
               end
            end
            default: begin
               w_rpt_next     = RPT_IDLE;
               w_rpt_cnt_next = '0;
            end
         endcase
      end
   end
`else
   assign w_rpt_push = 1'b0;
`endif

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_keycode  <= '0;
         r_prev     <= '0;
         r_mods     <= '0;
         r_latch    <= '0;
         r_strobe   <= 1'b0;
         r_overflow <= 1'b0;
         r_wr_ptr   <= '0;
         r_rd_ptr   <= '0;
         r_count    <= '0;
         for (int unsigned i = 0; i < FIFO_DEPTH; i++) begin
            r_fifo[i] <= '0;
         end
      end else begin
         r_keycode <= keycode;
         r_mods    <= kb_mods;
         r_prev    <= r_keycode;

         if (w_push) begin
            r_fifo[r_wr_ptr] <= w_ascii;
            r_wr_ptr         <= r_wr_ptr + 1'b1;
         end
         if (w_pop) begin
            r_latch  <= r_fifo[r_rd_ptr];
            r_rd_ptr <= r_rd_ptr + 1'b1;
         end
         case ({w_push, w_pop})
            2'b10:   r_count <= r_count + 1'b1;
            2'b01:   r_count <= r_count - 1'b1;
            default: r_count <= r_count;
         endcase

         // a pop only happens while the strobe is clear, so it wins
         if (w_pop) begin
            r_strobe <= 1'b1;
         end else if (w_strb_clr) begin
            r_strobe <= 1'b0;
         end

         if (w_drop) begin
            r_overflow <= 1'b1;
         end
      end
   end

   assign any_key_down = (r_keycode != HID_NONE);
   assign overflow     = r_overflow;
   assign fifo_count   = r_count;
   assign data_sel     = (addr & 16'hFFE0) == KBD_ADDR;

   always_comb begin
      data_out = '0;
      if (w_in_kbd) begin
         data_out = {r_strobe, r_latch};
      end else if (w_in_strb) begin
         data_out = {any_key_down, r_latch};
      end
   end

endmodule
